branch_resolve_unit: RTL and testbench

In-order branch resolution queue between dispatch and the common data bus (CDB).
- Accepts conditional branches from the decoder/dispatch with operand values or producer tags.
- Captures missing operands by snooping CDB broadcasts.
- Evaluates each branch condition and broadcasts {pc, taken} on the CDB in strict program order.
- Program order matters because the branch predictor pops its prediction queue head-first and compares its head address against cdb_addr; out-of-order resolution would mis-pop that queue.

---
 rtl/branch_resolve_unit_if.sv | 41 ++++
 rtl/branch_resolve_unit.sv | 146 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Dispatch, CDB-snoop and CDB-broadcast signal bundle for branch_resolve_unit.
// slave = the resolution queue, master = the dispatch/CDB side that drives it.
interface branch_resolve_unit_if #(
    parameter int TAG_W = 4
);
    logic             issue_valid;
    logic [2:0]       issue_op;
    logic [31:0]      issue_pc;
    logic             issue_rs1_rdy;
    logic [31:0]      issue_rs1_val;
    logic [TAG_W-1:0] issue_rs1_tag;
    logic             issue_rs2_rdy;
    logic [31:0]      issue_rs2_val;
    logic [TAG_W-1:0] issue_rs2_tag;
    logic             issue_full;

    logic             snoop_valid;
    logic [TAG_W-1:0] snoop_tag;
    logic [31:0]      snoop_val;

    logic             bc_valid;
    logic [31:0]      bc_addr;
    logic [31:0]      bc_val;
    logic             bc_gnt;

    modport slave (
        input  issue_valid, issue_op, issue_pc,
               issue_rs1_rdy, issue_rs1_val, issue_rs1_tag,
               issue_rs2_rdy, issue_rs2_val, issue_rs2_tag,
               snoop_valid, snoop_tag, snoop_val, bc_gnt,
        output issue_full, bc_valid, bc_addr, bc_val
    );

    modport master (
        output issue_valid, issue_op, issue_pc,
               issue_rs1_rdy, issue_rs1_val, issue_rs1_tag,
               issue_rs2_rdy, issue_rs2_val, issue_rs2_tag,
               snoop_valid, snoop_tag, snoop_val, bc_gnt,
        input  issue_full, bc_valid, bc_addr, bc_val
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order branch resolution queue: captures operands from the CDB snoop and broadcasts
// {pc, taken} in program order. Optional macro BRU_SNOOP_BYPASS_EN evaluates the head with this cycle's snoop.
module branch_resolve_unit #(
    parameter int BRU_SIZE   = 4,
    parameter int BRU_SIZE_W = 2,
    parameter int TAG_W      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    branch_resolve_unit_if.slave  bus,
    output logic [BRU_SIZE_W:0]   count
);
    localparam logic [BRU_SIZE_W:0] FULL_CNT = (BRU_SIZE_W+1)'(BRU_SIZE);

    logic [BRU_SIZE_W-1:0] front, rear;
    logic [BRU_SIZE_W:0]   cnt;
    logic [BRU_SIZE-1:0]   e_vld, e_r1_rdy, e_r2_rdy;
    logic [2:0]            e_op     [BRU_SIZE];
    logic [31:0]           e_pc     [BRU_SIZE];
    logic [31:0]           e_r1_val [BRU_SIZE];
    logic [31:0]           e_r2_val [BRU_SIZE];
    logic [TAG_W-1:0]      e_r1_tag [BRU_SIZE];
    logic [TAG_W-1:0]      e_r2_tag [BRU_SIZE];

    logic        vld_p1;
    logic [31:0] bc_addr_p1;
    logic        taken_p1;

    logic        active, full, pop, push, iss1_hit, iss2_hit;
    logic        h1_rdy, h2_rdy;
    logic [31:0] h1_val, h2_val;

    function automatic logic eval_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        h1_rdy = e_r1_rdy[front];
        h2_rdy = e_r2_rdy[front];
        h1_val = e_r1_val[front];
        h2_val = e_r2_val[front];
`ifdef BRU_SNOOP_BYPASS_EN
        if (bus.snoop_valid && !e_r1_rdy[front] && e_r1_tag[front] == bus.snoop_tag) begin
            h1_rdy = 1'b1;
            h1_val = bus.snoop_val;
        end
        if (bus.snoop_valid && !e_r2_rdy[front] && e_r2_tag[front] == bus.snoop_tag) begin
            h2_rdy = 1'b1;
            h2_val = bus.snoop_val;
        end
`endif
    end

    assign active   = rdy_in && !flush_in;
    assign full     = (cnt == FULL_CNT);
    assign pop      = active && e_vld[front] && h1_rdy && h2_rdy && (!vld_p1 || bus.bc_gnt);
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push     = active && bus.issue_valid && (!full || pop);
    assign iss1_hit = bus.snoop_valid && !bus.issue_rs1_rdy && bus.issue_rs1_tag == bus.snoop_tag;
    assign iss2_hit = bus.snoop_valid && !bus.issue_rs2_rdy && bus.issue_rs2_tag == bus.snoop_tag;

    // Control: pointers, occupancy, entry valids and the broadcast register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            front      <= '0;
            rear       <= '0;
            cnt        <= '0;
            e_vld      <= '0;
            vld_p1     <= 1'b0;
            bc_addr_p1 <= '0;
            taken_p1   <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                front  <= '0;
                rear   <= '0;
                cnt    <= '0;
                e_vld  <= '0;
                vld_p1 <= 1'b0;
            end else begin
                if (pop) begin
                    front        <= front + BRU_SIZE_W'(1);
                    e_vld[front] <= 1'b0;
                end
                if (push) begin
                    rear        <= rear + BRU_SIZE_W'(1);
                    e_vld[rear] <= 1'b1;
                end
                cnt <= cnt + (BRU_SIZE_W+1)'(push) - (BRU_SIZE_W+1)'(pop);
                if (pop) begin
                    vld_p1     <= 1'b1;
                    bc_addr_p1 <= e_pc[front];
                    taken_p1   <= eval_cond(e_op[front], h1_val, h2_val);
                end else if (bus.bc_gnt) begin
                    vld_p1 <= 1'b0;
                end
            end
        end
    end

    // Entry payload: snoop capture, then the issue write (which wins on the rear slot).
    always_ff @(posedge clk_in) begin
        if (active) begin
            for (int i = 0; i < BRU_SIZE; i++) begin
                if (e_vld[i] && bus.snoop_valid) begin
                    if (!e_r1_rdy[i] && e_r1_tag[i] == bus.snoop_tag) begin
                        e_r1_rdy[i] <= 1'b1;
                        e_r1_val[i] <= bus.snoop_val;
                    end
                    if (!e_r2_rdy[i] && e_r2_tag[i] == bus.snoop_tag) begin
                        e_r2_rdy[i] <= 1'b1;
                        e_r2_val[i] <= bus.snoop_val;
                    end
                end
            end
            if (push) begin
                e_op[rear]     <= bus.issue_op;
                e_pc[rear]     <= bus.issue_pc;
                e_r1_rdy[rear] <= bus.issue_rs1_rdy || iss1_hit;
                e_r1_val[rear] <= iss1_hit ? bus.snoop_val : bus.issue_rs1_val;
                e_r1_tag[rear] <= bus.issue_rs1_tag;
                e_r2_rdy[rear] <= bus.issue_rs2_rdy || iss2_hit;
                e_r2_val[rear] <= iss2_hit ? bus.snoop_val : bus.issue_rs2_val;
                e_r2_tag[rear] <= bus.issue_rs2_tag;
            end
        end
    end

    assign bus.issue_full = full;
    assign bus.bc_valid   = vld_p1;
    assign bus.bc_addr    = bc_addr_p1;
    assign bus.bc_val     = {31'b0, taken_p1};
    assign count          = cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: ordering, signed/unsigned compares, snoop, full, flush, pause, reset.
module tb_branch_resolve_unit;
    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       rdy_in = 1'b1;
    logic       flush_in = 1'b0;
    logic [2:0] count;
    int         total = 0;
    int         fails = 0;

    branch_resolve_unit_if #(.TAG_W(4)) bus ();

    branch_resolve_unit #(.BRU_SIZE(4), .BRU_SIZE_W(2), .TAG_W(4)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus),
        .count    (count)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] pc,
                         input logic r1_rdy, input logic [31:0] r1_val, input logic [3:0] r1_tag,
                         input logic r2_rdy, input logic [31:0] r2_val, input logic [3:0] r2_tag);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = op;
        bus.issue_pc      = pc;
        bus.issue_rs1_rdy = r1_rdy;
        bus.issue_rs1_val = r1_val;
        bus.issue_rs1_tag = r1_tag;
        bus.issue_rs2_rdy = r2_rdy;
        bus.issue_rs2_val = r2_val;
        bus.issue_rs2_tag = r2_tag;
    endtask

    task automatic wait_bc(input string tag);
        int n;
        n = 0;
        while (!bus.bc_valid && n < 4) begin
            step();
            n++;
        end
        chk(tag, bus.bc_valid, 1);
    endtask

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_op = 3'b000;
        bus.issue_pc = '0;
        bus.issue_rs1_rdy = 1'b0;
        bus.issue_rs1_val = '0;
        bus.issue_rs1_tag = '0;
        bus.issue_rs2_rdy = 1'b0;
        bus.issue_rs2_val = '0;
        bus.issue_rs2_tag = '0;
        bus.snoop_valid = 1'b0;
        bus.snoop_tag = '0;
        bus.snoop_val = '0;
        bus.bc_gnt = 1'b0;

        step();
        step();
        chk("rst_bc_valid", bus.bc_valid, 0);
        chk("rst_bc_addr", bus.bc_addr, 0);
        chk("rst_bc_val", bus.bc_val, 0);
        chk("rst_count", count, 0);
        chk("rst_full", bus.issue_full, 0);
        rst_in = 1'b1;

        // BEQ equal operands, one-cycle latency then drop
        bus.bc_gnt = 1'b1;
        issue(3'b000, 32'h100, 1, 5, 0, 1, 5, 0);
        step();
        bus.issue_valid = 1'b0;
        chk("t1_count", count, 1);
        step();
        chk("t1_valid", bus.bc_valid, 1);
        chk("t1_addr", bus.bc_addr, 32'h100);
        chk("t1_val", bus.bc_val, 1);
        step();
        chk("t1_drop", bus.bc_valid, 0);

        // signed vs unsigned compare on the same operands
        issue(3'b100, 32'h110, 1, 32'hFFFF_FFFF, 0, 1, 1, 0);
        step();
        issue(3'b110, 32'h114, 1, 32'hFFFF_FFFF, 0, 1, 1, 0);
        step();
        bus.issue_valid = 1'b0;
        chk("t2_blt_addr", bus.bc_addr, 32'h110);
        chk("t2_blt_val", bus.bc_val, 1);
        step();
        chk("t2_bltu_addr", bus.bc_addr, 32'h114);
        chk("t2_bltu_val", bus.bc_val, 0);
        step();
        chk("t2_drop", bus.bc_valid, 0);

        // not-ready head blocks a ready younger branch
        issue(3'b001, 32'h200, 0, 0, 3, 1, 7, 0);
        step();
        issue(3'b000, 32'h204, 1, 1, 0, 1, 1, 0);
        step();
        bus.issue_valid = 1'b0;
        chk("t3_blocked", bus.bc_valid, 0);
        chk("t3_count", count, 2);
        step();
        chk("t3_blocked2", bus.bc_valid, 0);
        bus.snoop_valid = 1'b1;
        bus.snoop_tag = 4'd3;
        bus.snoop_val = 32'd7;
        step();
        bus.snoop_valid = 1'b0;
        wait_bc("t3_wait");
        chk("t3_first_addr", bus.bc_addr, 32'h200);
        chk("t3_first_val", bus.bc_val, 0);
        step();
        chk("t3_second_addr", bus.bc_addr, 32'h204);
        chk("t3_second_val", bus.bc_val, 1);
        step();
        chk("t3_drop", bus.bc_valid, 0);

        // fill, hold without grant, dropped overflow push, pop+push, drain in order
        bus.bc_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(3'b000, 32'h300 + 32'(4 * i), 1, 2, 0, 1, 2, 0);
            step();
        end
        bus.issue_valid = 1'b0;
        chk("t4_count", count, 4);
        chk("t4_full", bus.issue_full, 1);
        chk("t4_bc_addr", bus.bc_addr, 32'h300);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_addr", bus.bc_addr, 32'h300);
        end
        chk("t4_hold_valid", bus.bc_valid, 1);
        issue(3'b000, 32'hDEAD, 1, 0, 0, 1, 0, 0);
        step();
        chk("t4_overflow_count", count, 4);
        issue(3'b000, 32'h314, 1, 3, 0, 1, 3, 0);
        bus.bc_gnt = 1'b1;
        chk("t4_full_prepop", bus.issue_full, 1);
        step();
        bus.issue_valid = 1'b0;
        chk("t4_pushpop_count", count, 4);
        chk("t4_pushpop_addr", bus.bc_addr, 32'h304);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_drain_addr", bus.bc_addr, 32'h308 + 32'(4 * i));
            chk("t4_drain_count", count, 32'(3 - i));
        end
        step();
        chk("t4_empty", bus.bc_valid, 0);

        // flush beats issue and grant in the same cycle
        bus.bc_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(3'b000, 32'h400 + 32'(4 * i), 1, 1, 0, 1, 1, 0);
            step();
        end
        chk("t5_pre_count", count, 3);
        chk("t5_pre_valid", bus.bc_valid, 1);
        issue(3'b000, 32'h500, 1, 1, 0, 1, 1, 0);
        bus.bc_gnt = 1'b1;
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        bus.issue_valid = 1'b0;
        chk("t5_count", count, 0);
        chk("t5_valid", bus.bc_valid, 0);
        chk("t5_full", bus.issue_full, 0);
        step();
        chk("t5_discard", bus.bc_valid, 0);

        // pause with snoop and grant asserted
        bus.bc_gnt = 1'b0;
        issue(3'b000, 32'h5F0, 1, 1, 0, 1, 1, 0);
        step();
        issue(3'b001, 32'h600, 0, 0, 5, 1, 9, 0);
        step();
        bus.issue_valid = 1'b0;
        chk("t6_pre_addr", bus.bc_addr, 32'h5F0);
        chk("t6_pre_count", count, 1);
        rdy_in = 1'b0;
        bus.snoop_valid = 1'b1;
        bus.snoop_tag = 4'd5;
        bus.snoop_val = 32'd9;
        bus.bc_gnt = 1'b1;
        step();
        step();
        chk("t6_pause_valid", bus.bc_valid, 1);
        chk("t6_pause_addr", bus.bc_addr, 32'h5F0);
        chk("t6_pause_count", count, 1);
        rdy_in = 1'b1;
        bus.snoop_valid = 1'b0;
        step();
        chk("t6_nocapture", bus.bc_valid, 0);
        chk("t6_still_queued", count, 1);
        bus.snoop_valid = 1'b1;
        step();
        bus.snoop_valid = 1'b0;
        bus.bc_gnt = 1'b0;
        wait_bc("t6_wait");
        chk("t6_addr", bus.bc_addr, 32'h600);
        chk("t6_val", bus.bc_val, 0);

        // asynchronous reset mid-broadcast
        #2;
        rst_in = 1'b0;
        #1;
        chk("t6_async_valid", bus.bc_valid, 0);
        chk("t6_async_addr", bus.bc_addr, 0);
        chk("t6_async_count", count, 0);
        step();
        rst_in = 1'b1;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
